// File: rtl/data_collector_pretrig.sv
// Purpose : multi-channel snapshot buffer with pre-trigger history, decimation and a selectable trigger.
// Latency : a captured sample reaches RAM one cycle after its we strobe; bus_rdata is valid 2 cycles after bus_rd.
// Backpressure: none. Samples that are not captured (decimated, or outside a capture) are dropped.
// Ports: clk/resetn (async, active-low); data/we/ext_trig form the sampled datapath;
//        bus_addr/bus_wdata/bus_wr/bus_rd/bus_rdata form the register bus; busy/irq report capture status.
module data_collector_pretrig #(
  parameter int          BASE_ADDR       = 0,
  parameter int          BUS_ADDR_WIDTH  = 32,
  parameter int          NUM_PORTS       = 3,
  parameter int          DATA_WIDTH      = 31,
  parameter int          DATA_DEPTH      = 12369,
  parameter logic [31:0] DATA_COLL_CONST = 32'hDC0C0002
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data,
  input  logic                            we,
  input  logic                            ext_trig,
  input  logic [BUS_ADDR_WIDTH-1:0]       bus_addr,
  input  logic [31:0]                     bus_wdata,
  input  logic                            bus_wr,
  input  logic                            bus_rd,
  output logic [31:0]                     bus_rdata,
  output logic                            busy,
  output logic                            irq
);
  localparam int AW = $clog2(DATA_DEPTH + 1);
  localparam int RW = NUM_PORTS * DATA_WIDTH;
  localparam logic [AW-1:0] DEPTH_MAX = AW'(DATA_DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0, S_PREFILL = 3'd1, S_WAIT = 3'd2, S_POST = 3'd3, S_DONE = 3'd4;

  localparam logic [3:0] R_CONST = 4'd0, R_CTRL = 4'd1, R_STATUS = 4'd2, R_DEPTH = 4'd3,
                         R_PRETRIG = 4'd4, R_DECIM = 4'd5, R_TRIG = 4'd6, R_THRESH = 4'd7,
                         R_CHAN = 4'd8, R_RAM = 4'd9, R_TPOS = 4'd10;

  logic [2:0]    state;
  logic [AW-1:0] depth, pretrig, wr_ptr, rd_ptr, cnt, trig_pos;
  logic [15:0]   decim, dcnt;
  logic [1:0]    mode;
  logic [3:0]    tchan, chan;
  logic [31:0]   thresh;
  logic          done_flag, pending, ext_q, samp_vld;
  logic [RW-1:0] samp_q;
  logic [2:0]    srst_cnt;
  logic          srst;

  // ---------------- register decode ----------------
  logic [BUS_ADDR_WIDTH-1:0] off;
  logic                      hit;
  logic [3:0]                ridx;
  assign off  = bus_addr - BUS_ADDR_WIDTH'(BASE_ADDR);
  assign hit  = (bus_addr >= BUS_ADDR_WIDTH'(BASE_ADDR)) && (off <= BUS_ADDR_WIDTH'(10));
  assign ridx = off[3:0];

  logic wr_any, wr_ctrl, cfg_ok, do_abort, do_arm, active, rd_ram_adv;
  assign srst       = (srst_cnt != 3'd0);
  assign wr_any     = bus_wr && hit && !srst;
  assign wr_ctrl    = wr_any && (ridx == R_CTRL);
  assign cfg_ok     = (state == S_IDLE) || (state == S_DONE);
  // abort beats arm; a soft reset in the same word overrides both
  assign do_abort   = wr_ctrl && !bus_wdata[0] && bus_wdata[2];
  assign do_arm     = wr_ctrl && !bus_wdata[0] && !bus_wdata[2] && bus_wdata[1] && cfg_ok;
  assign active     = (state == S_PREFILL) || (state == S_WAIT) || (state == S_POST);
  assign rd_ram_adv = bus_rd && hit && (ridx == R_RAM) && (state == S_DONE);
  assign busy       = active;

  // Soft reset: internal reset held for 4 cycles after the CTRL write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                                 srst_cnt <= 3'd0;
    else if (srst)                                               srst_cnt <= srst_cnt - 3'd1;
    else if (bus_wr && hit && (ridx == R_CTRL) && bus_wdata[0])  srst_cnt <= 3'd4;
  end

  // ---------------- configuration registers ----------------
  logic [AW-1:0] dm1, depth_new, dnew_m1, pretrig_new;
  assign dm1     = depth - AW'(1);
  assign dnew_m1 = depth_new - AW'(1);

  always_comb begin
    if (bus_wdata == 32'd0)                  depth_new = AW'(1);
    else if (bus_wdata > 32'(DATA_DEPTH))    depth_new = DEPTH_MAX;
    else                                     depth_new = bus_wdata[AW-1:0];
    if (bus_wdata > 32'(dm1))                pretrig_new = dm1;
    else                                     pretrig_new = bus_wdata[AW-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      depth <= DEPTH_MAX; pretrig <= '0; decim <= '0; mode <= '0; tchan <= '0; thresh <= '0; chan <= '0;
    end else if (srst) begin
      depth <= DEPTH_MAX; pretrig <= '0; decim <= '0; mode <= '0; tchan <= '0; thresh <= '0; chan <= '0;
    end else if (wr_any) begin
      case (ridx)
        R_DEPTH: if (cfg_ok) begin
          depth <= depth_new;
          // keep PRETRIG consistent with a shrinking DEPTH
          if (pretrig > dnew_m1) pretrig <= dnew_m1;
        end
        R_PRETRIG: if (cfg_ok) pretrig <= pretrig_new;
        R_DECIM:   if (cfg_ok) decim <= bus_wdata[15:0];
        R_TRIG:    if (cfg_ok) begin mode <= bus_wdata[1:0]; tchan <= bus_wdata[11:8]; end
        R_THRESH:  thresh <= bus_wdata;
        R_CHAN:    chan <= bus_wdata[3:0];
        default: ;
      endcase
    end
  end

  // ---------------- sample capture (decimation) ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      samp_vld <= 1'b0; samp_q <= '0; dcnt <= '0; ext_q <= 1'b0;
    end else begin
      ext_q    <= ext_trig;
      samp_vld <= 1'b0;
      if (srst || do_arm) dcnt <= '0;
      else if (we && active) begin
        dcnt <= (dcnt == decim) ? 16'd0 : dcnt + 16'd1;
        if (dcnt == 16'd0) begin
          samp_vld <= 1'b1;
          samp_q   <= data;
        end
      end
    end
  end

  // ---------------- trigger evaluation on the registered sample ----------------
  logic signed [DATA_WIDTH-1:0] tsamp, thr;
  logic                         trig_hit;
  assign thr = thresh[DATA_WIDTH-1:0];
  always_comb begin
    tsamp = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (tchan == 4'(i)) tsamp = samp_q[i*DATA_WIDTH +: DATA_WIDTH];
    case (mode)
      2'd0:    trig_hit = 1'b1;
      2'd1:    trig_hit = pending;
      2'd2:    trig_hit = (tsamp > thr);
      default: trig_hit = (tsamp < thr);
    endcase
  end

  logic [AW-1:0] ptr_next, post_n, trig_addr, start;
  assign ptr_next  = (wr_ptr == dm1) ? '0 : wr_ptr + AW'(1);
  assign post_n    = dm1 - pretrig;
  // when POST is skipped, the trigger address is still the live write pointer
  assign trig_addr = (state == S_WAIT) ? wr_ptr : trig_pos;
  assign start     = (trig_addr >= pretrig) ? trig_addr - pretrig : trig_addr + depth - pretrig;

  // ---------------- capture state machine ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE; wr_ptr <= '0; rd_ptr <= '0; cnt <= '0; trig_pos <= '0;
      pending <= 1'b0; done_flag <= 1'b0; irq <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (srst) begin
        state <= S_IDLE; wr_ptr <= '0; rd_ptr <= '0; cnt <= '0; trig_pos <= '0;
        pending <= 1'b0; done_flag <= 1'b0;
      end else if (do_abort) begin
        state   <= S_IDLE;
        pending <= 1'b0;
      end else if (do_arm) begin
        state     <= (pretrig == '0) ? S_WAIT : S_PREFILL;
        wr_ptr    <= '0;
        cnt       <= '0;
        pending   <= 1'b0;
        done_flag <= 1'b0;
      end else begin
        if (state == S_WAIT && ext_trig && !ext_q) pending <= 1'b1;
        if (wr_any && ridx == R_CHAN) rd_ptr <= start;
        else if (rd_ram_adv)          rd_ptr <= (rd_ptr == dm1) ? '0 : rd_ptr + AW'(1);
        if (samp_vld) begin
          case (state)
            S_PREFILL: begin
              wr_ptr <= ptr_next;
              if (cnt == pretrig - AW'(1)) begin state <= S_WAIT; cnt <= '0; end
              else cnt <= cnt + AW'(1);
            end
            S_WAIT: begin
              wr_ptr <= ptr_next;
              if (trig_hit) begin
                trig_pos <= wr_ptr;
                pending  <= 1'b0;
                cnt      <= '0;
                if (post_n == '0) begin
                  state <= S_DONE; irq <= 1'b1; done_flag <= 1'b1; rd_ptr <= start;
                end else state <= S_POST;
              end
            end
            S_POST: begin
              wr_ptr <= ptr_next;
              if (cnt == post_n - AW'(1)) begin
                state <= S_DONE; irq <= 1'b1; done_flag <= 1'b1; rd_ptr <= start;
              end else cnt <= cnt + AW'(1);
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- sample RAM ----------------
  logic [RW-1:0] mem [DATA_DEPTH];
  logic [RW-1:0] ram_q;
  logic          ram_we;
  assign ram_we = samp_vld && active && !srst && !do_abort;

  always_ff @(posedge clk) begin
    if (ram_we)     mem[wr_ptr] <= samp_q;
    if (rd_ram_adv) ram_q <= mem[rd_ptr];
  end

  // ---------------- read path: decode stage, then output register ----------------
  logic [31:0] reg_val, ram_word, rd_val1;
  logic        rd_v1, rd_ram1;

  always_comb begin
    reg_val = '0;
    if (hit) begin
      case (ridx)
        R_CONST:   reg_val = srst ? 32'd0 : DATA_COLL_CONST;
        R_STATUS:  reg_val = {28'd0, done_flag, state};
        R_DEPTH:   reg_val = 32'(depth);
        R_PRETRIG: reg_val = 32'(pretrig);
        R_DECIM:   reg_val = 32'(decim);
        R_TRIG:    reg_val = {20'd0, tchan, 6'd0, mode};
        R_THRESH:  reg_val = thresh;
        R_CHAN:    reg_val = 32'(chan);
        R_TPOS:    reg_val = 32'(trig_pos);
        default:   reg_val = '0;
      endcase
    end
  end

  always_comb begin
    ram_word = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (chan == 4'(i)) ram_word = 32'(ram_q[i*DATA_WIDTH +: DATA_WIDTH]);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_v1 <= 1'b0; rd_ram1 <= 1'b0; rd_val1 <= '0; bus_rdata <= '0;
    end else begin
      rd_v1 <= bus_rd;
      if (bus_rd) begin
        rd_ram1 <= rd_ram_adv;
        rd_val1 <= reg_val;
      end
      if (rd_v1) bus_rdata <= rd_ram1 ? ram_word : rd_val1;
    end
  end

endmodule

// File: tb/tb_data_collector_pretrig.sv
module tb_data_collector_pretrig;
  localparam int          NP     = 3;
  localparam int          DW     = 31;
  localparam int          DD     = 12369;
  localparam logic [31:0] CONSTV = 32'hDC0C0002;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [NP*DW-1:0] data = '0;
  logic             we = 1'b0, ext_trig = 1'b0, bus_wr = 1'b0, bus_rd = 1'b0;
  logic [31:0]      bus_addr = '0, bus_wdata = '0;
  logic [31:0]      bus_rdata;
  logic             busy, irq;

  data_collector_pretrig #(
    .BASE_ADDR(0), .BUS_ADDR_WIDTH(32), .NUM_PORTS(NP), .DATA_WIDTH(DW),
    .DATA_DEPTH(DD), .DATA_COLL_CONST(CONSTV)
  ) dut (
    .clk(clk), .resetn(resetn), .data(data), .we(we), .ext_trig(ext_trig),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_rdata(bus_rdata), .busy(busy), .irq(irq)
  );

  initial forever #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_pend = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every read pushes its expectation; the result appears 2 edges later.
  always @(posedge clk) begin
    logic fire;
    fire    = rd_pend;
    rd_pend = bus_rd;
    if (fire) begin
      #2;
      if (exp_q.size() == 0) check_val("sb_underflow", 32'(exp_q.size()), 32'd1);
      else check_val(tag_q.pop_front(), bus_rdata, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int a, input logic [31:0] v);
    bus_addr = 32'(a); bus_wdata = v; bus_wr = 1'b1;
    tick();
    bus_wr = 1'b0;
  endtask

  task automatic bus_read(input int a, input logic [31:0] e, input string tag);
    bus_addr = 32'(a); bus_rd = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    tick();
    bus_rd = 1'b0;
  endtask

  task automatic flush();
    repeat (3) tick();
  endtask

  // kind 0: channel c = 1000*c + n ; kind 1: channel 1 = n - 20 (signed), others offset by 100 per channel
  function automatic logic [DW-1:0] sval(input int kind, input int c, input int n);
    logic [31:0] v;
    if (kind == 0) v = 32'(1000 * c + n);
    else           v = 32'(n - 120 + 100 * c);
    return v[DW-1:0];
  endfunction

  // Drives we strobes (every cycle, or every other cycle when gap=1) until irq or max_n strobes.
  // cnt_at_irq = number of strobes sampled by the DUT when irq is first seen, else -1.
  task automatic run_capture(input int kind, input int gap, input int ext_at, input int max_n,
                             output int cnt_at_irq);
    int n = 0;
    int sampled = 0;
    cnt_at_irq = -1;
    while (n < max_n) begin
      we = 1'b1;
      for (int c = 0; c < NP; c++) data[c*DW +: DW] = sval(kind, c, n);
      tick();
      sampled++; n++;
      we = 1'b0;
      if (irq) begin cnt_at_irq = sampled; break; end
      if (gap != 0) begin
        ext_trig = (n == ext_at);
        tick();
        ext_trig = 1'b0;
        if (irq) begin cnt_at_irq = sampled; break; end
      end
    end
    we = 1'b0;
  endtask

  task automatic rd_ram(input int c, input int nreads, input int kind, input int first,
                        input int dec, input int depth);
    bus_write(8, 32'(c));
    for (int k = 0; k < nreads; k++) begin
      int s;
      s = first + (k % depth);
      bus_read(9, 32'(sval(kind, c, s * (dec + 1))), $sformatf("ram_c%0d_r%0d", c, k));
    end
    flush();
  endtask

  // First captured index (at or after the prefill) whose channel-1 value exceeds -5.
  function automatic int first_trig(input int dec, input int pre);
    logic signed [DW-1:0] v;
    for (int i = pre; i < 1000; i++) begin
      v = sval(1, 1, i * (dec + 1));
      if (v > -5) return i;
    end
    return -1;
  endfunction

  initial begin
    int cnt;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // reset state
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_rdata", bus_rdata, 32'd0);
    bus_read(0, CONSTV, "rst_const");
    bus_read(2, 32'd0, "rst_status");
    bus_read(3, 32'(DD), "rst_depth");
    bus_read(4, 32'd0, "rst_pretrig");
    bus_read(5, 32'd0, "rst_decim");
    bus_read(6, 32'd0, "rst_trigcfg");
    bus_read(7, 32'd0, "rst_thresh");
    bus_read(8, 32'd0, "rst_chan");
    bus_read(10, 32'd0, "rst_trigpos");
    bus_read(11, 32'd0, "unmapped");
    flush();

    // soft reset
    bus_write(5, 32'd7);
    bus_write(1, 32'd1);
    bus_read(0, 32'd0, "srst_const0");
    bus_read(0, 32'd0, "srst_const1");
    repeat (4) tick();
    bus_read(0, CONSTV, "srst_const_after");
    bus_read(5, 32'd0, "srst_decim_default");
    flush();

    // clamping
    bus_write(3, 32'd0);      bus_read(3, 32'd1, "depth_clamp0");
    bus_write(4, 32'd5);      bus_read(4, 32'd0, "pretrig_clamp_d1");
    bus_write(3, 32'd100000); bus_read(3, 32'(DD), "depth_clamp_max");
    bus_write(3, 32'd64);
    bus_write(4, 32'd64);     bus_read(4, 32'd63, "pretrig_clamp");
    bus_read(3, 32'd64, "depth_64");
    flush();

    // mode 0, full depth, no pretrigger
    bus_write(3, 32'(DD)); bus_write(4, 0); bus_write(5, 0); bus_write(6, 0);
    bus_write(1, 32'd2);
    run_capture(0, 0, -1, DD + 10, cnt);
    check_val("m0_irq_cnt", 32'(cnt), 32'(DD + 1));
    check_val("m0_busy_done", 32'(busy), 32'd0);
    tick();
    check_val("m0_irq_pulse", 32'(irq), 32'd0);
    bus_read(2, 32'hC, "m0_status");
    bus_read(10, 32'd0, "m0_trigpos");
    flush();
    for (int c = 0; c < NP; c++) rd_ram(c, DD, 0, 0, 0, DD);

    // mode 1, external trigger
    bus_write(3, 64); bus_write(4, 16); bus_write(6, 1);
    bus_write(1, 32'd2);
    run_capture(0, 1, 100, 400, cnt);
    check_val("m1_irq_cnt", 32'(cnt), 32'd148);
    bus_read(2, 32'hC, "m1_status");
    bus_read(10, 32'd36, "m1_trigpos");
    flush();
    rd_ram(0, 65, 0, 84, 0, 64);

    // mode 2 on channel 1, with and without decimation
    for (int d = 0; d <= 3; d += 3) begin
      int t;
      t = first_trig(d, 4);
      bus_write(3, 32); bus_write(4, 4); bus_write(5, 32'(d));
      bus_write(6, 32'h102); bus_write(7, 32'hFFFF_FFFB);
      bus_write(1, 32'd2);
      run_capture(1, 0, -1, 1000, cnt);
      check_val($sformatf("m2_d%0d_irq_cnt", d), 32'(cnt), 32'((t + 27) * (d + 1) + 2));
      bus_read(10, 32'(t % 32), $sformatf("m2_d%0d_trigpos", d));
      flush();
      rd_ram(1, 32, 1, t - 4, d, 32);
    end

    // abort during WAIT_TRIG, arm-while-busy ignored, then a clean re-arm
    bus_write(3, 64); bus_write(4, 0); bus_write(5, 0); bus_write(6, 1);
    bus_write(1, 32'd2);
    run_capture(0, 0, -1, 20, cnt);
    check_val("ab_no_irq", 32'(cnt), 32'hFFFF_FFFF);
    check_val("ab_busy", 32'(busy), 32'd1);
    bus_write(1, 32'd2);
    bus_read(2, 32'd2, "ab_status_wait");
    bus_write(1, 32'd6);
    bus_read(2, 32'd0, "ab_status_idle");
    bus_read(9, 32'd0, "ab_ram0");
    bus_read(9, 32'd0, "ab_ram1");
    flush();
    check_val("ab_busy_after", 32'(busy), 32'd0);
    check_val("ab_irq_after", 32'(irq), 32'd0);
    bus_write(6, 0); bus_write(3, 16); bus_write(4, 3);
    bus_write(1, 32'd2);
    run_capture(0, 0, -1, 100, cnt);
    check_val("rearm_irq_cnt", 32'(cnt), 32'd17);
    bus_read(10, 32'd3, "rearm_trigpos");
    flush();
    rd_ram(2, 16, 0, 0, 0, 16);

    // hardware reset in the middle of POST
    bus_write(3, 64); bus_write(4, 0); bus_write(6, 0);
    bus_write(1, 32'd2);
    run_capture(0, 0, -1, 10, cnt);
    check_val("post_busy", 32'(busy), 32'd1);
    bus_read(2, 32'd3, "post_status");
    flush();
    resetn = 1'b0;
    #1;
    check_val("hrst_busy", 32'(busy), 32'd0);
    check_val("hrst_irq", 32'(irq), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    bus_read(2, 32'd0, "hrst_status");
    bus_read(3, 32'(DD), "hrst_depth");
    flush();

    check_val("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_collector_pretrig.md
# data_collector_pretrig

Multi-channel snapshot capture buffer with pre-trigger history, decimation and selectable trigger source. It is the successor to the plain data collector: samples from NUM_PORTS parallel channels are written into a circular RAM, and each snapshot keeps PRETRIG samples from before the trigger event. Results are read back over the register bus in chronological order. It sits on the debug bus beside other register-mapped debug blocks and shares one clock with the sampled datapath.

## Interface
- BASE_ADDR, 0: word address of register 0 on the bus.
- BUS_ADDR_WIDTH, 32: width of bus_addr.
- NUM_PORTS, 3: number of captured channels, 1..16.
- DATA_WIDTH, 31: bits per channel, 1..32.
- DATA_DEPTH, 12369: maximum samples per channel; need not be a power of two.
- DATA_COLL_CONST, 32'hDC0C0002: identification constant.
- clk  in  1  capture and bus clock.
- resetn  in  1  reset, asynchronous, active-low.
- data  in  NUM_PORTS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- we  in  1  sample-valid strobe, common to all channels.
- ext_trig  in  1  external trigger, synchronous to clk.
- bus_addr  in  BUS_ADDR_WIDTH  word address.
- bus_wdata  in  32  write data.
- bus_wr  in  1  one-cycle write strobe.
- bus_rd  in  1  one-cycle read strobe.
- bus_rdata  out  32  read data.
- busy  out  1  high in PREFILL, WAIT_TRIG and POST.
- irq  out  1  one-cycle pulse on entry to DONE.

## Operation
Register offsets are relative to BASE_ADDR.

- 0 CONST (RO): returns DATA_COLL_CONST. Returns 0 while a soft reset is in progress.
- 1 CTRL (WO, self-clearing):
  - bit0 soft reset: all registers return to defaults, state returns to IDLE.
  - bit1 arm: accepted only in IDLE or DONE.
  - bit2 abort: any state goes to IDLE; irq is not raised.
- 2 STATUS (RO): [2:0] state code (IDLE=0, PREFILL=1, WAIT_TRIG=2, POST=3, DONE=4); [3] done flag, cleared on arm.
- 3 DEPTH (RW): snapshot length. Writes of 0 or values above DATA_DEPTH are clamped to the range 1..DATA_DEPTH.
- 4 PRETRIG (RW): pre-trigger sample count. Clamped to DEPTH-1.
- 5 DECIM (RW, 16 bit): one sample is captured every DECIM+1 `we` strobes. The decimation counter restarts on arm.
- 6 TRIG_CFG (RW):
  - [1:0] mode: 0 = software (fires immediately); 1 = ext_trig rising edge; 2 = signed sample > THRESH; 3 = signed sample < THRESH.
  - [11:8] trigger channel for modes 2 and 3.
- 7 THRESH (RW): signed threshold, using the low DATA_WIDTH bits.
- 8 CHAN (RW): read-back channel. Writing it resets the read pointer to START.
- 9 RAM (RO): returns the sample at the read pointer for channel CHAN, zero-extended to 32 bits. The read pointer then advances, wrapping DEPTH-1 to 0. Returns 0 outside DONE.
- 10 TRIG_POS (RO): RAM address holding the trigger sample.
- Other offsets read 0; writes to them are ignored.

State machine (all state changes are counted on captured samples):
- IDLE: no RAM writes. arm goes to PREFILL, or straight to WAIT_TRIG when PRETRIG = 0. The write pointer is cleared to 0.
- PREFILL: writes captured samples. Triggers are ignored. After PRETRIG samples have been stored, goes to WAIT_TRIG.
- WAIT_TRIG: circular writes continue, wrapping at DEPTH-1.
  - The first captured sample that meets the trigger condition is stored and is the trigger sample. TRIG_POS is latched to its address. Go to POST.
  - Mode 0 triggers on the first captured sample in this state.
  - Mode 1: an ext_trig rising edge sets a pending flag. The next captured sample is the trigger sample.
- POST: stores DEPTH-PRETRIG-1 further samples, then goes to DONE. When that count is 0, POST exits on the same cycle as the trigger sample.
- DONE: the RAM is frozen. START = (TRIG_POS - PRETRIG) mod DEPTH, the oldest sample. The read pointer is set to START on entry.
- CONST, CTRL and DEPTH through TRIG_CFG keep their values across arm.
- DEPTH, PRETRIG, DECIM and TRIG_CFG writes outside IDLE and DONE are ignored.

## Timing
- Reset values:
  - Outputs: bus_rdata = 0, busy = 0, irq = 0.
  - Registers: DEPTH = DATA_DEPTH, PRETRIG = 0, DECIM = 0, TRIG_CFG = 0, THRESH = 0, CHAN = 0; state IDLE.
- Register writes take effect on the cycle after bus_wr.
- bus_rdata is valid 2 cycles after bus_rd for every offset (synchronous RAM read plus an output register). It holds until the next read.
- Back-to-back RAM reads are allowed, one per cycle, and return consecutive samples.
- Soft reset holds the internal reset for 4 cycles. CONST reads 0 during those cycles and reads the constant afterwards.
- A captured sample is written to RAM one cycle after its `we` strobe. The trigger compare uses that same registered sample.
- busy falls and irq pulses in the cycle after the last POST write.
- arm and abort in the same write: abort wins.
- arm written during PREFILL, WAIT_TRIG or POST: ignored.
- Asserting resetn low mid-capture forces IDLE immediately. RAM contents are then undefined.

## Test plan
- Soft reset, then poll CONST: the first reads return 0, and a read 5 or more cycles later returns 32'hDC0C0002.
- Mode 0, DEPTH=12369, PRETRIG=0, DECIM=0, ramp data (channel c = 1000*c + n), arm:
  - irq after 12369 captured samples, TRIG_POS = 0.
  - Reading each channel returns 1000*c + 0 .. 12368 in order.
- Mode 1, DEPTH=64, PRETRIG=16, ext_trig pulse at sample 100:
  - TRIG_POS = 100 mod 64 = 36.
  - The first RAM read returns sample 84 and the 17th returns sample 100.
  - The 64th read returns sample 147; read 65 wraps back to sample 84.
- Mode 2 on channel 1 with THRESH=-5 and a signed ramp from -20: the trigger sample is the first sample with value -4.
  - Repeat with DECIM=3: only every 4th `we` strobe is captured.
- Abort during WAIT_TRIG: STATUS reads 0, no irq, RAM reads return 0. A later arm completes normally.
- Writes of DEPTH=0 and PRETRIG=DEPTH: read back as 1 and DEPTH-1.
  - Toggle resetn mid-POST: busy = 0 and STATUS = 0 within one cycle.
